seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode N-digit 7-segment display on the Alhambra II board. It shares the single segment bus between digits by sequencing the anode enables with a fixed slot time and an anti-ghosting blanking gap. Digit values arrive through a valid/ready load port and are double-buffered, so a new value set only takes effect at a frame boundary and the display never shows a torn frame. It sits between application logic (counters, status) and the display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (≥2)
SLOT_CYC, 12000, clk cycles per digit slot (1 kHz per digit at 12 MHz)
BLANK_CYC, 600, cycles at slot start with all anodes off; 0 ≤ BLANK_CYC < SLOT_CYC
SEG_ACT_LOW, 1, 1 = seg/dp active-low
AN_ACT_LOW, 1, 1 = anodes active-low

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable
load_valid  in  1  new digit set offered
load_ready  out  1  controller can accept a new set
load_data  in  4*N_DIGITS  hex nibbles; digit i = [4i+3:4i]
load_dp  in  N_DIGITS  decimal point per digit
blank_mask  in  N_DIGITS  1 = digit i stays dark (live, not buffered)
seg  out  7  {g,f,e,d,c,b,a}
dp  out  1  decimal point
an  out  N_DIGITS  anode enables
frame_done  out  1  one-cycle pulse at the end of the digit N_DIGITS-1 slot

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, idx=0, shadow and pending regs cleared to 0, pend_v=0. Outputs: all anodes inactive, all segments and dp inactive, load_ready=1, frame_done=0.
- Registers: pending (data, dp, pend_v) and shadow (displayed). A transfer occurs when load_valid & load_ready. It captures into pending and sets pend_v. load_ready = ~pend_v.
- Shadow update: pending → shadow and pend_v cleared on the frame_done cycle, or on any cycle in IDLE. load_ready rises the cycle after.
- FSM states: IDLE, BLANK, DRIVE. cnt counts 0..SLOT_CYC-1 within a slot.
  - IDLE → BLANK when en=1, with cnt=0 and idx=0. If BLANK_CYC=0, go to DRIVE directly.
  - BLANK → DRIVE when cnt==BLANK_CYC-1.
  - DRIVE at cnt==SLOT_CYC-1: cnt←0, idx←(idx==N_DIGITS-1)?0:idx+1, next state BLANK (or DRIVE if BLANK_CYC=0). frame_done=1 on this cycle when idx==N_DIGITS-1.
  - en=0 in any state → IDLE next cycle, cnt and idx cleared. A pending load is still accepted.
- Outputs (registered, one cycle behind state/cnt/idx):
  - an[idx] is active only while in DRIVE and blank_mask[idx]=0.
  - seg/dp = decode(shadow nibble idx) during DRIVE; otherwise inactive.
  - Masked digits keep full slot timing.
- frame_done is registered, aligned with the last DRIVE output cycle of the final digit.
- Hex decode, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. The result is inverted when SEG_ACT_LOW.
- Simultaneous transfer and frame_done: shadow takes the old pending, and the new transfer lands in pending. This case is impossible, since load_ready=0 while pend_v=1.
- Width: cnt is $clog2(SLOT_CYC) bits; idx is $clog2(N_DIGITS) bits.

Decomposition:
- Shared package/header (seg7_pkg): FSM state encodings and the hex→segment constant table.
- One sub-module, seg7_hex_decode: combinational nibble → 7-bit segments, polarity parameterized.
- The scan FSM, counters and buffers stay in seg7_scan_ctrl.

Test Plan:
Bench parameters: N_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2, active-low.
1. Reset: hold rst_n=0 mid-DRIVE → same cycle an=4'b1111, seg=7'h7F, dp=1, load_ready=1, frame_done=0.
2. Normal scan: load 16'h1234, dp=0, en=1 → slot 0 is 2 cycles an=1111, then 6 cycles an=1110 with seg=7'h19 ('4'); next slot an=1101 with seg=7'h30 ('3'). frame_done pulses every 32 cycles.
3. No tearing: load 16'hABCD during the digit-1 slot → load_ready=0 next cycle; digits 2–3 still show '2','1'. Next frame shows D,C,b,A (7'h21,7'h46,7'h03,7'h08). load_ready=1 the cycle after frame_done.
4. Masking: blank_mask=4'b0100 → an[2] is never low; slot spacing unchanged, frame_done still every 32 cycles.
5. Enable drop: en=0 at cnt=4 of the digit-2 DRIVE → an=1111 within 1 cycle. On en=1, 2 blank cycles, then digit 0 drives.
6. BLANK_CYC=0 corner: an is active in all 8 cycles of each slot, with a clean 1-cycle anode handover and no two anodes active together.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM state encoding
// and the hex-to-segment lookup table (active-high, bit order {g,f,e,d,c,b,a}).
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decoder with selectable polarity.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Look the glyph up in the shared table, then flip it for active-low pins.
  always_comb begin
    seg = HEX_SEG[nibble];
    if (ACT_LOW) seg = ~seg;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Each digit gets a fixed slot: a short all-dark gap against ghosting,
// then the digit is driven. New digit sets are double-buffered (pending ->
// shadow) and only reach the display at a frame boundary or while idle.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SLOT_CYC    = 12000,
  parameter int BLANK_CYC   = 600,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_data,
  input  logic [N_DIGITS-1:0]   load_dp,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  // With no blanking gap every slot starts straight in DRIVE.
  localparam scan_state_t SLOT_START = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  localparam logic [6:0]          SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = SEG_ACT_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? '1 : '0;

  scan_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic frame_end;

  logic [4*N_DIGITS-1:0] pend_data, shadow_data, shadow_data_nxt;
  logic [N_DIGITS-1:0]   pend_dp, shadow_dp, shadow_dp_nxt;
  logic                  pend_v;
  logic                  load_fire;
  logic                  shadow_take;

  logic [3:0]          nibble;
  logic                dp_bit;
  logic [N_DIGITS-1:0] an_sel;
  logic [6:0]          seg_dec;
  logic                drive_now;

  assign load_ready  = ~pend_v;
  assign load_fire   = load_valid & ~pend_v;
  assign shadow_take = pend_v & (frame_done | (state == ST_IDLE));
  assign drive_now   = en & (state == ST_DRIVE);

  // Scan FSM register: state, slot cycle counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; dropping en parks the scanner in IDLE from any state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    frame_end = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = SLOT_START;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        ST_BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_nxt = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            state_nxt = SLOT_START;
            frame_end = (idx == IDX_LAST);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Pending buffer captures offered sets and is drained into the shadow copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_v      <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      shadow_data <= shadow_data_nxt;
      shadow_dp   <= shadow_dp_nxt;
      if (load_fire) begin
        pend_data <= load_data;
        pend_dp   <= load_dp;
        pend_v    <= 1'b1;
      end else if (shadow_take) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Shadow value as of the next edge; decoding from it means the first
  // driven cycle of a new frame already shows the new set even without a gap.
  always_comb begin
    shadow_data_nxt = shadow_take ? pend_data : shadow_data;
    shadow_dp_nxt   = shadow_take ? pend_dp   : shadow_dp;
  end

  // Pick the current digit's nibble, dp bit and (unless masked) its anode.
  always_comb begin
    nibble = '0;
    dp_bit = 1'b0;
    an_sel = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble    = shadow_data_nxt[4*i +: 4];
        dp_bit    = shadow_dp_nxt[i];
        an_sel[i] = ~blank_mask[i];
      end
    end
  end

  seg7_hex_decode #(
    .ACT_LOW (SEG_ACT_LOW)
  ) u_hex_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // Registered pins: driven only in DRIVE, otherwise every line inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (drive_now) begin
        seg <= seg_dec;
        dp  <= SEG_ACT_LOW ? ~dp_bit : dp_bit;
        an  <= AN_ACT_LOW ? ~an_sel : an_sel;
      end else begin
        seg <= SEG_OFF;
        dp  <= DP_OFF;
        an  <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed scoreboard bench for seg7_scan_ctrl: a 2-cycle-gap instance and a
// zero-gap instance share all inputs; expectations are queued per cycle.
module tb_seg7_scan_ctrl;

  typedef enum int {
    SIG_AN, SIG_SEG, SIG_DP, SIG_FD, SIG_RDY,
    SIG_NB_AN, SIG_NB_SEG, SIG_NB_DP, SIG_NB_FD, SIG_NB_RDY, SIG_NB_ONEHOT
  } sig_e;

  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [6:0] val;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  blank_mask;

  logic       load_ready, dp, frame_done;
  logic [6:0] seg;
  logic [3:0] an;
  logic       nb_load_ready, nb_dp, nb_frame_done;
  logic [6:0] nb_seg;
  logic [3:0] nb_an;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seg7_scan_ctrl #(
    .N_DIGITS(4), .SLOT_CYC(8), .BLANK_CYC(2), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .blank_mask(blank_mask),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  seg7_scan_ctrl #(
    .N_DIGITS(4), .SLOT_CYC(8), .BLANK_CYC(0), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_ready(nb_load_ready),
    .load_data(load_data), .load_dp(load_dp), .blank_mask(blank_mask),
    .seg(nb_seg), .dp(nb_dp), .an(nb_an), .frame_done(nb_frame_done)
  );

  task automatic expectAt(input int c, input sig_e s, input logic [6:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] obs;
    case (e.sig)
      SIG_AN:        obs = {3'b000, an};
      SIG_SEG:       obs = seg;
      SIG_DP:        obs = {6'b0, dp};
      SIG_FD:        obs = {6'b0, frame_done};
      SIG_RDY:       obs = {6'b0, load_ready};
      SIG_NB_AN:     obs = {3'b000, nb_an};
      SIG_NB_SEG:    obs = nb_seg;
      SIG_NB_DP:     obs = {6'b0, nb_dp};
      SIG_NB_FD:     obs = {6'b0, nb_frame_done};
      SIG_NB_RDY:    obs = {6'b0, nb_load_ready};
      SIG_NB_ONEHOT: obs = 7'($countones(~nb_an));
      default:       obs = 'x;
    endcase
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", e.tag, e.cyc, obs, e.val);
    end
  endtask

  // Pops every queued expectation that falls due in the current cycle.
  task automatic scanScoreboard();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  endtask

  task automatic waitCycle(input int k);
    while (cyc < k) begin
      @(negedge clk);
      scanScoreboard();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int at, input logic en_v, input logic lv,
                               input logic [15:0] ld, input logic [3:0] ldp,
                               input logic [3:0] bm);
    waitCycle(at);
    en         = en_v;
    load_valid = lv;
    load_data  = ld;
    load_dp    = ldp;
    blank_mask = bm;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    blank_mask = '0;

    // Reset values.
    expectAt(2, SIG_AN,    7'h0F, "reset_an");
    expectAt(2, SIG_SEG,   7'h7F, "reset_seg");
    expectAt(2, SIG_DP,    7'h01, "reset_dp");
    expectAt(2, SIG_FD,    7'h00, "reset_fd");
    expectAt(2, SIG_RDY,   7'h01, "reset_rdy");
    expectAt(2, SIG_NB_AN, 7'h0F, "reset_nb_an");
    waitCycle(3);
    rst_n = 1'b1;

    // Load 1234 while idle: ready drops for one cycle, then shadow takes it.
    applyStimulus(4, 1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
    expectAt(4, SIG_RDY, 7'h01, "idle_rdy_before");
    expectAt(5, SIG_RDY, 7'h00, "idle_rdy_busy");
    expectAt(6, SIG_RDY, 7'h01, "idle_rdy_after");
    applyStimulus(5, 1'b0, 1'b0, 16'h1234, 4'h0, 4'h0);

    // Start scanning.
    applyStimulus(6, 1'b1, 1'b0, 16'h1234, 4'h0, 4'h0);
    expectAt(8,  SIG_AN,  7'h0F, "slot0_blank_a");
    expectAt(9,  SIG_AN,  7'h0F, "slot0_blank_b");
    expectAt(10, SIG_AN,  7'h0E, "slot0_first_an");
    expectAt(10, SIG_SEG, 7'h19, "slot0_seg4");
    expectAt(10, SIG_DP,  7'h01, "slot0_dp_off");
    expectAt(15, SIG_AN,  7'h0E, "slot0_last_an");
    expectAt(15, SIG_SEG, 7'h19, "slot0_last_seg");
    expectAt(16, SIG_AN,  7'h0F, "slot1_blank_a");
    expectAt(17, SIG_AN,  7'h0F, "slot1_blank_b");
    expectAt(18, SIG_AN,  7'h0D, "slot1_an");
    expectAt(18, SIG_SEG, 7'h30, "slot1_seg3");
    expectAt(38, SIG_FD,  7'h00, "fd_before");
    expectAt(39, SIG_FD,  7'h01, "fd_frame0");
    expectAt(40, SIG_FD,  7'h00, "fd_after");
    expectAt(7,  SIG_NB_AN,  7'h0F, "nb_idle_an");
    expectAt(8,  SIG_NB_AN,  7'h0E, "nb_slot0_first");
    expectAt(8,  SIG_NB_SEG, 7'h19, "nb_slot0_seg4");
    expectAt(8,  SIG_NB_DP,  7'h01, "nb_slot0_dp");
    expectAt(15, SIG_NB_AN,  7'h0E, "nb_slot0_last");
    expectAt(16, SIG_NB_AN,  7'h0D, "nb_handover01");
    expectAt(23, SIG_NB_AN,  7'h0D, "nb_slot1_last");
    expectAt(24, SIG_NB_AN,  7'h0B, "nb_handover12");
    expectAt(39, SIG_NB_AN,  7'h07, "nb_slot3_last");
    expectAt(39, SIG_NB_FD,  7'h01, "nb_fd_frame0");
    for (int c = 8; c <= 39; c++) expectAt(c, SIG_NB_ONEHOT, 7'd1, "nb_onehot");

    // Offer ABCD during digit 1: current frame must finish with 2, 1.
    applyStimulus(18, 1'b1, 1'b1, 16'hABCD, 4'b0010, 4'h0);
    expectAt(18, SIG_RDY,    7'h01, "tear_rdy_before");
    expectAt(19, SIG_RDY,    7'h00, "tear_rdy_busy");
    expectAt(19, SIG_NB_RDY, 7'h00, "nb_tear_rdy_busy");
    expectAt(26, SIG_AN,     7'h0B, "tear_d2_an");
    expectAt(26, SIG_SEG,    7'h24, "tear_d2_old2");
    expectAt(34, SIG_AN,     7'h07, "tear_d3_an");
    expectAt(34, SIG_SEG,    7'h79, "tear_d3_old1");
    expectAt(39, SIG_RDY,    7'h00, "tear_rdy_at_fd");
    expectAt(40, SIG_RDY,    7'h01, "tear_rdy_after_fd");
    expectAt(42, SIG_AN,     7'h0E, "new_d0_an");
    expectAt(42, SIG_SEG,    7'h21, "new_d0_segD");
    expectAt(42, SIG_DP,     7'h01, "new_d0_dp");
    expectAt(50, SIG_AN,     7'h0D, "new_d1_an");
    expectAt(50, SIG_SEG,    7'h46, "new_d1_segC");
    expectAt(50, SIG_DP,     7'h00, "new_d1_dp_on");
    expectAt(58, SIG_SEG,    7'h03, "new_d2_segb");
    expectAt(66, SIG_SEG,    7'h08, "new_d3_segA");
    expectAt(71, SIG_FD,     7'h01, "fd_frame1");
    expectAt(72, SIG_FD,     7'h00, "fd_frame1_after");
    applyStimulus(19, 1'b1, 1'b0, 16'hABCD, 4'b0010, 4'h0);

    // Mask digit 2 for one frame.
    applyStimulus(72, 1'b1, 1'b0, 16'hABCD, 4'b0010, 4'b0100);
    expectAt(82,  SIG_AN,    7'h0D, "mask_d1_an");
    expectAt(90,  SIG_AN,    7'h0F, "mask_d2_first");
    expectAt(93,  SIG_AN,    7'h0F, "mask_d2_mid");
    expectAt(95,  SIG_AN,    7'h0F, "mask_d2_last");
    expectAt(90,  SIG_NB_AN, 7'h0F, "nb_mask_d2");
    expectAt(98,  SIG_AN,    7'h07, "mask_d3_an");
    expectAt(102, SIG_FD,    7'h00, "mask_fd_before");
    expectAt(103, SIG_FD,    7'h01, "mask_fd_frame2");
    applyStimulus(104, 1'b1, 1'b0, 16'hABCD, 4'b0010, 4'h0);

    // Drop en at cnt 4 of digit 2, load 5678 while idle, then restart.
    applyStimulus(155, 1'b0, 1'b0, 16'hABCD, 4'b0010, 4'h0);
    expectAt(155, SIG_AN,    7'h0B, "endrop_before");
    expectAt(156, SIG_AN,    7'h0F, "endrop_dark");
    expectAt(156, SIG_NB_AN, 7'h0F, "nb_endrop_dark");
    expectAt(158, SIG_AN,    7'h0F, "endrop_idle");
    applyStimulus(156, 1'b0, 1'b1, 16'h5678, 4'h0, 4'h0);
    expectAt(157, SIG_RDY, 7'h00, "idle2_rdy_busy");
    expectAt(158, SIG_RDY, 7'h01, "idle2_rdy_after");
    applyStimulus(157, 1'b0, 1'b0, 16'h5678, 4'h0, 4'h0);
    applyStimulus(159, 1'b1, 1'b0, 16'h5678, 4'h0, 4'h0);
    expectAt(160, SIG_AN,    7'h0F, "restart_idle");
    expectAt(161, SIG_AN,    7'h0F, "restart_blank_a");
    expectAt(162, SIG_AN,    7'h0F, "restart_blank_b");
    expectAt(163, SIG_AN,    7'h0E, "restart_d0_an");
    expectAt(163, SIG_SEG,   7'h00, "restart_d0_seg8");
    expectAt(163, SIG_DP,    7'h01, "restart_d0_dp");
    expectAt(171, SIG_AN,    7'h0D, "restart_d1_an");
    expectAt(171, SIG_SEG,   7'h78, "restart_d1_seg7");
    expectAt(160, SIG_NB_AN, 7'h0F, "nb_restart_idle");
    expectAt(161, SIG_NB_AN, 7'h0E, "nb_restart_d0");
    expectAt(191, SIG_FD,    7'h00, "restart_fd_before");
    expectAt(192, SIG_FD,    7'h01, "restart_fd");

    // Leave a set pending, then hit reset in the middle of a DRIVE slot.
    applyStimulus(195, 1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0);
    expectAt(196, SIG_RDY, 7'h00, "prereset_rdy_busy");
    expectAt(196, SIG_AN,  7'h0E, "prereset_driving");
    applyStimulus(196, 1'b1, 1'b0, 16'hFFFF, 4'hF, 4'h0);
    waitCycle(197);
    rst_n = 1'b0;
    expectAt(197, SIG_AN,    7'h0F, "async_reset_an");
    expectAt(197, SIG_SEG,   7'h7F, "async_reset_seg");
    expectAt(197, SIG_DP,    7'h01, "async_reset_dp");
    expectAt(197, SIG_FD,    7'h00, "async_reset_fd");
    expectAt(197, SIG_RDY,   7'h01, "async_reset_rdy");
    expectAt(197, SIG_NB_AN, 7'h0F, "async_reset_nb_an");
    waitCycle(199);
    rst_n = 1'b1;
    en    = 1'b0;
    waitCycle(203);
    @(negedge clk);
    scanScoreboard();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
